hyperbus_mem_responder: RTL and testbench
=========================================

# hyperbus_mem_responder

Synthesizable HyperBus device-side responder that sits on the memory end of the HyperBus PHY pins, opposite the SoC's HyperBus controller. It decodes the 48-bit command/address (CA) phase, enforces initial latency, and serves linear or wrapped read and write bursts from an internal byte array. It also implements configuration register 0 (CR0). It is the controller's counterpart for FPGA and loopback builds where the behavioural HyperRAM model cannot be used. One DDR half-edge of the HyperBus clock maps to one `clk_i` cycle, carrying one byte per cycle.

## Interface
- `MemBytes`, default 4096: backing array size in bytes; power of two, ≥ 32.
- `LatencyCycles`, default 6: initial latency in CK cycles; range 3..7.
- `DoubleLatency`, default 1'b1: 1 drives RWDS high in CA (2× latency); 0 drives RWDS low (1× latency).
- `Cr0Reset`, default 16'h8F1F: CR0 reset value.
- `clk_i`, in, 1: system clock (2× HyperBus CK).
- `rst_ni`, in, 1: asynchronous active-low reset.
- `hyper_reset_ni`, in, 1: device reset from the controller; synchronous, active-low.
- `hyper_cs_ni`, in, 1: chip select, active-low.
- `hyper_dq_i`, in, 8: DQ from the controller.
- `hyper_dq_o`, out, 8: DQ driven by the device.
- `hyper_dq_oe_o`, out, 1: DQ output enable.
- `hyper_rwds_i`, in, 1: RWDS from the controller, used as the write byte mask.
- `hyper_rwds_o`, out, 1: RWDS driven by the device.
- `hyper_rwds_oe_o`, out, 1: RWDS output enable.
- `cr0_o`, out, 16: current CR0 value, for observation.

## Operation
- States: IDLE, CA, LAT, RD, WR, REGWR, HOLD.
- IDLE: a sampled `hyper_cs_ni`=0 with a byte present captures CA byte 0 and enters CA.
- CA: captures 6 bytes total, MSB first, into `ca[47:0]`.
  - `ca[47]`: 1=read.
  - `ca[46]`: 1=register space.
  - `ca[45]`: 1=linear, 0=wrapped.
  - Word address `w = {ca[44:16], ca[2:0]}` mod MemBytes/2.
- After byte 6:
  - Register write goes to REGWR, with zero latency.
  - Otherwise goes to LAT with `L = 2*LatencyCycles*(DoubleLatency?2:1)` cycles.
  - The multiplier comes from `DoubleLatency`, not from the CR0 bit.
- LAT: counts down L cycles, then enters RD or WR.
- RD: two byte slots per word.
  - Slot A drives `mem[2w+1]` with `hyper_rwds_o`=1.
  - Slot B drives `mem[2w]` with `hyper_rwds_o`=0.
  - Register-space reads return CR0[15:8], then CR0[7:0], repeating.
- WR: slot A sampled byte → `mem[2w+1]`; slot B sampled byte → `mem[2w]`.
  - A byte is written only if `hyper_rwds_i`=0 in its slot.
  - `hyper_rwds_i`=1 masks that byte.
- Word address advance after slot B:
  - Linear: `w+1` mod MemBytes/2.
  - Wrapped: `w[3:0]` increments mod 16 and the upper bits are held (32-byte wrap).
- REGWR: the first 2 bytes are written to CR0 {hi, lo}, unmasked, then the block enters HOLD.
- HOLD: ignores bus activity until `hyper_cs_ni` rises.
- `hyper_cs_ni`=1 in any state returns the block to IDLE on the next edge.
  - A partially received word is discarded.
  - A write with only slot A complete still commits slot A.
- `hyper_reset_ni`=0: state forced to IDLE and CR0 restored to `Cr0Reset`; the array is unchanged.
- The array is never reset.

## Timing
- Reset values:
  - `hyper_dq_o`=0.
  - `hyper_dq_oe_o`=0.
  - `hyper_rwds_o`=0.
  - `hyper_rwds_oe_o`=0.
  - `cr0_o`=`Cr0Reset`.
  - State=IDLE.
- Cycle 0 is the first cycle with `hyper_cs_ni`=0. CA bytes are sampled at the end of cycles 0..5.
- RWDS during CA:
  - `hyper_rwds_oe_o`=1 from cycle 1 through cycle 5+L.
  - `hyper_rwds_o`=`DoubleLatency` during CA and LAT.
- Latency occupies cycles 6..5+L.
- Read:
  - First data byte valid on `hyper_dq_o` in cycle 6+L; one byte per cycle thereafter.
  - `hyper_dq_oe_o` and `hyper_rwds_oe_o` stay 1 while in RD.
  - Data and RWDS outputs are registered.
  - Both output enables are gated combinationally with `~hyper_cs_ni`, so they drop in the same cycle CS rises.
- Write: data sampled at the end of cycles 6+L onward; `hyper_rwds_oe_o`=0 from cycle 6+L.
- Register write: data sampled at the end of cycles 6 and 7; `cr0_o` updates in cycle 8.
- Back-to-back transactions: CS high for one cycle is sufficient; a new CA may start in the next cycle.
- Asynchronous reset mid-transaction: all outputs drop immediately.

## Test plan
- Memory linear write then read:
  - Stimulus: write to w=0x10, linear, bytes AA 55 12 34, RWDS low. Then read the same address.
  - Required response: `mem[0x21]`=AA, `mem[0x20]`=55, `mem[0x23]`=12, `mem[0x22]`=34.
  - Read data appears in cycle 6+24=30 as AA 55 12 34, with `hyper_rwds_o` toggling 1,0,1,0.
- Masked write:
  - Stimulus: write to w=0x10 with bytes FF FF, RWDS mask 1 in slot A, 0 in slot B.
  - Required response: `mem[0x21]` unchanged, `mem[0x20]`=FF.
- Wrapped read:
  - Stimulus: read starting at w=0x1E with ca[45]=0, 4 words.
  - Required response: words 0x1E, 0x1F, 0x10, 0x11 are returned.
- Register write then read:
  - Stimulus: register write CR0=16'h8F17.
  - Required response: `cr0_o`=8F17 in cycle 8; a subsequent register read returns 8F 17.
- Aborted read:
  - Stimulus: CS rises in cycle 31 during RD.
  - Required response: `hyper_dq_oe_o` and `hyper_rwds_oe_o` are 0 in cycle 31. A new CA at cycle 33 is decoded correctly.
- Device reset mid-latency:
  - Stimulus: `hyper_reset_ni` pulsed low during LAT.
  - Required response: state returns to IDLE, no data is driven, `cr0_o`=8F1F, and array contents are preserved.

Source files
------------

// File: rtl/hyperbus_mem_responder.sv
// HyperBus device-side responder: decodes the 48-bit CA phase, enforces initial latency,
// and serves linear/wrapped bursts from an internal byte array plus configuration register CR0.
module hyperbus_mem_responder #(
   parameter int unsigned MemBytes      = 4096,
   parameter int unsigned LatencyCycles = 6,
   parameter bit          DoubleLatency = 1'b1,
   parameter logic [15:0] Cr0Reset      = 16'h8F1F
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        hyper_reset_ni,
   input  logic        hyper_cs_ni,
   input  logic [7:0]  hyper_dq_i,
   output logic [7:0]  hyper_dq_o,
   output logic        hyper_dq_oe_o,
   input  logic        hyper_rwds_i,
   output logic        hyper_rwds_o,
   output logic        hyper_rwds_oe_o,
   output logic [15:0] cr0_o
);
   localparam int unsigned AW = $clog2(MemBytes / 2);
   localparam int unsigned Lat = 2 * LatencyCycles * (DoubleLatency ? 2 : 1);
   localparam logic [AW-1:0] WrapMask = AW'(15);

   typedef enum logic [2:0] {IDLE, CA, LAT, RD, WR, REGWR, HOLD} state_t;

   state_t        state;
   logic [39:0]   ca_shift;
   logic [2:0]    ca_cnt;
   logic [5:0]    lat_cnt;
   logic          is_read;
   logic          is_reg;
   logic          linear;
   logic          slot_b;
   logic [AW-1:0] w;
   logic [7:0]    cr0_hi;
   logic [15:0]   cr0;
   logic [7:0]    dq;
   logic          dq_oe;
   logic          rwds;
   logic          rwds_oe;

   logic [7:0]    mem [MemBytes];

   logic [47:0]   ca_full;
   logic [31:0]   ca_word;
   logic [AW-1:0] w_adv;
   logic          next_a;
   logic [AW:0]   raddr;
   logic [AW:0]   waddr;
   logic [7:0]    rd_byte;
   logic          mem_we;
   logic          unused_ca;

   always_comb begin
      ca_full = {ca_shift, hyper_dq_i};
      ca_word = {ca_full[44:16], ca_full[2:0]};
      // Wrapped bursts stay inside the aligned 16-word (32-byte) group
      w_adv   = linear ? w + 1'b1 : ((w & ~WrapMask) | ((w + 1'b1) & WrapMask));
      next_a  = !(state == RD && !slot_b);
      raddr   = next_a ? {((state == RD) ? w_adv : w), 1'b1} : {w, 1'b0};
      rd_byte = is_reg ? (next_a ? cr0[15:8] : cr0[7:0]) : mem[raddr];
      mem_we  = (state == WR) && hyper_reset_ni && !hyper_cs_ni && !hyper_rwds_i;
      waddr   = {w, ~slot_b};
   end

   assign unused_ca = ^{ca_full[15:3], ca_word[31:AW]};

   always_ff @(posedge clk_i) begin
      if (mem_we) mem[waddr] <= hyper_dq_i;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state    <= IDLE;
         ca_shift <= '0;
         ca_cnt   <= '0;
         lat_cnt  <= '0;
         is_read  <= 1'b0;
         is_reg   <= 1'b0;
         linear   <= 1'b0;
         slot_b   <= 1'b0;
         w        <= '0;
         cr0_hi   <= '0;
         cr0      <= Cr0Reset;
         dq       <= '0;
         dq_oe    <= 1'b0;
         rwds     <= 1'b0;
         rwds_oe  <= 1'b0;
      end else if (!hyper_reset_ni || hyper_cs_ni) begin
         state   <= IDLE;
         dq      <= '0;
         dq_oe   <= 1'b0;
         rwds    <= 1'b0;
         rwds_oe <= 1'b0;
         if (!hyper_reset_ni) cr0 <= Cr0Reset;
      end else begin
         case (state)
            IDLE: begin
               ca_shift <= {32'd0, hyper_dq_i};
               ca_cnt   <= 3'd1;
               rwds     <= DoubleLatency;
               rwds_oe  <= 1'b1;
               state    <= CA;
            end
            CA: begin
               ca_shift <= ca_full[39:0];
               ca_cnt   <= ca_cnt + 1'b1;
               if (ca_cnt == 3'd5) begin
                  is_read <= ca_full[47];
                  is_reg  <= ca_full[46];
                  linear  <= ca_full[45];
                  w       <= ca_word[AW-1:0];
                  slot_b  <= 1'b0;
                  if (!ca_full[47] && ca_full[46]) begin
                     state   <= REGWR;
                     rwds_oe <= 1'b0;
                  end else begin
                     state   <= LAT;
                     lat_cnt <= 6'(Lat - 1);
                  end
               end
            end
            LAT: begin
               if (lat_cnt == '0) begin
                  if (is_read) begin
                     state <= RD;
                     dq_oe <= 1'b1;
                     rwds  <= 1'b1;
                     dq    <= rd_byte;
                  end else begin
                     state   <= WR;
                     rwds    <= 1'b0;
                     rwds_oe <= 1'b0;
                  end
               end else begin
                  lat_cnt <= lat_cnt - 1'b1;
               end
            end
            RD: begin
               // Load the byte for the next slot; RWDS is high for the upper byte
               dq     <= rd_byte;
               rwds   <= slot_b;
               slot_b <= ~slot_b;
               if (slot_b) w <= w_adv;
            end
            WR: begin
               slot_b <= ~slot_b;
               if (slot_b) w <= w_adv;
            end
            REGWR: begin
               slot_b <= ~slot_b;
               if (!slot_b) begin
                  cr0_hi <= hyper_dq_i;
               end else begin
                  cr0   <= {cr0_hi, hyper_dq_i};
                  state <= HOLD;
               end
            end
            HOLD: state <= HOLD;
            default: state <= IDLE;
         endcase
      end
   end

   assign hyper_dq_o      = dq;
   assign hyper_rwds_o    = rwds;
   assign hyper_dq_oe_o   = dq_oe & ~hyper_cs_ni;
   assign hyper_rwds_oe_o = rwds_oe & ~hyper_cs_ni;
   assign cr0_o           = cr0;
endmodule

// File: tb/tb_hyperbus_mem_responder.sv
// Directed testbench for hyperbus_mem_responder: a table of bus transactions with
// hand-computed read data, plus sequences for abort, device reset and async reset.
module tb_hyperbus_mem_responder;
   localparam int Lat = 24;

   logic        clk_i = 1'b0;
   logic        rst_ni;
   logic        hyper_reset_ni;
   logic        hyper_cs_ni;
   logic [7:0]  hyper_dq_i;
   logic [7:0]  hyper_dq_o;
   logic        hyper_dq_oe_o;
   logic        hyper_rwds_i;
   logic        hyper_rwds_o;
   logic        hyper_rwds_oe_o;
   logic [15:0] cr0_o;

   hyperbus_mem_responder #(
      .MemBytes(4096), .LatencyCycles(6), .DoubleLatency(1'b1), .Cr0Reset(16'h8F1F)
   ) dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .hyper_reset_ni(hyper_reset_ni),
      .hyper_cs_ni(hyper_cs_ni), .hyper_dq_i(hyper_dq_i), .hyper_dq_o(hyper_dq_o),
      .hyper_dq_oe_o(hyper_dq_oe_o), .hyper_rwds_i(hyper_rwds_i),
      .hyper_rwds_o(hyper_rwds_o), .hyper_rwds_oe_o(hyper_rwds_oe_o), .cr0_o(cr0_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic        rd;
      logic        rg;
      logic        lin;
      logic [31:0] w;
      int          n;
      logic [63:0] bytes;  // byte i at [63-8i -: 8]
      logic [7:0]  mask;   // byte i masked when mask[7-i]
   } txn_t;

   int vec_cnt = 0;
   int err_cnt = 0;

   logic [7:0] s_dq;
   logic       s_dq_oe, s_rwds, s_rwds_oe;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vec_cnt++;
      if (act !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Drive one bus cycle, sample outputs mid-cycle, then move to the next cycle.
   task automatic step(input logic cs, input logic [7:0] d, input logic rw);
      hyper_cs_ni  = cs;
      hyper_dq_i   = d;
      hyper_rwds_i = rw;
      #1;
      s_dq      = hyper_dq_o;
      s_dq_oe   = hyper_dq_oe_o;
      s_rwds    = hyper_rwds_o;
      s_rwds_oe = hyper_rwds_oe_o;
      @(posedge clk_i);
      #1;
   endtask

   task automatic send_ca(input logic rd, input logic rg, input logic lin, input logic [31:0] w);
      logic [47:0] ca;
      ca = {rd, rg, lin, w[31:3], 13'd0, w[2:0]};
      for (int i = 0; i < 6; i++) begin
         step(1'b0, ca[47-8*i -: 8], 1'b0);
         if (i == 0) check("ca0_rwds_oe", 32'(s_rwds_oe), 32'd0);
         if (i == 1 || i == 5) begin
            check("ca_rwds_oe", 32'(s_rwds_oe), 32'd1);
            check("ca_rwds", 32'(s_rwds), 32'd1);
         end
      end
   endtask

   task automatic run_txn(input txn_t t, input int idx);
      int errs_before;
      errs_before = err_cnt;
      send_ca(t.rd, t.rg, t.lin, t.w);
      if (!t.rd && t.rg) begin
         step(1'b0, t.bytes[63 -: 8], 1'b0);
         step(1'b0, t.bytes[55 -: 8], 1'b0);
         check("cr0_cycle8", 32'(cr0_o), 32'(t.bytes[63:48]));
      end else begin
         for (int c = 0; c < Lat; c++) step(1'b0, 8'h00, 1'b0);
         check("lat_dq_oe", 32'(s_dq_oe), 32'd0);
         check("lat_rwds_oe", 32'(s_rwds_oe), 32'd1);
         for (int i = 0; i < t.n; i++) begin
            if (t.rd) begin
               step(1'b0, 8'h00, 1'b0);
               check("rd_data", 32'(s_dq), 32'(t.bytes[63-8*i -: 8]));
               check("rd_rwds", 32'(s_rwds), 32'(i % 2 == 0));
               check("rd_dq_oe", 32'(s_dq_oe), 32'd1);
            end else begin
               step(1'b0, t.bytes[63-8*i -: 8], t.mask[7-i]);
               check("wr_rwds_oe", 32'(s_rwds_oe), 32'd0);
            end
         end
      end
      step(1'b1, 8'h00, 1'b0);
      check("end_dq_oe", 32'(s_dq_oe), 32'd0);
      check("end_rwds_oe", 32'(s_rwds_oe), 32'd0);
      $display("txn %0d: %s %s %s w=%h n=%0d errors=%0d", idx, t.rd ? "RD" : "WR",
               t.rg ? "reg" : "mem", t.lin ? "linear" : "wrapped", t.w, t.n, err_cnt - errs_before);
   endtask

   txn_t vec [13];
   txn_t rb_1f_2 = '{rd: 1'b1, rg: 1'b0, lin: 1'b1, w: 32'h1F, n: 2, bytes: 64'h0708_0000_0000_0000, mask: 8'h00};
   txn_t rb_1f_4 = '{rd: 1'b1, rg: 1'b0, lin: 1'b1, w: 32'h1F, n: 4, bytes: 64'h0708_0B0C_0000_0000, mask: 8'h00};

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      vec[0]  = '{1'b0, 1'b0, 1'b1, 32'h10, 4, 64'hAA55_1234_0000_0000, 8'h00};
      vec[1]  = '{1'b1, 1'b0, 1'b1, 32'h10, 4, 64'hAA55_1234_0000_0000, 8'h00};
      vec[2]  = '{1'b0, 1'b0, 1'b1, 32'h10, 2, 64'hFFFF_0000_0000_0000, 8'b1000_0000};
      vec[3]  = '{1'b1, 1'b0, 1'b1, 32'h10, 2, 64'hAAFF_0000_0000_0000, 8'h00};
      vec[4]  = '{1'b0, 1'b0, 1'b1, 32'h1E, 4, 64'h0102_0304_0000_0000, 8'h00};
      vec[5]  = '{1'b0, 1'b0, 1'b1, 32'h11, 2, 64'h0506_0000_0000_0000, 8'h00};
      vec[6]  = '{1'b1, 1'b0, 1'b0, 32'h1E, 8, 64'h0102_0304_AAFF_0506, 8'h00};
      vec[7]  = '{1'b0, 1'b0, 1'b0, 32'h1F, 4, 64'h0708_090A_0000_0000, 8'h00};
      vec[8]  = '{1'b0, 1'b0, 1'b1, 32'h20, 2, 64'h0B0C_0000_0000_0000, 8'h00};
      vec[9]  = '{1'b1, 1'b0, 1'b0, 32'h10, 2, 64'h090A_0000_0000_0000, 8'h00};
      vec[10] = '{1'b1, 1'b0, 1'b1, 32'h1F, 4, 64'h0708_0B0C_0000_0000, 8'h00};
      vec[11] = '{1'b0, 1'b1, 1'b1, 32'h00, 2, 64'h8F17_0000_0000_0000, 8'h00};
      vec[12] = '{1'b1, 1'b1, 1'b1, 32'h00, 4, 64'h8F17_8F17_0000_0000, 8'h00};

      rst_ni = 1'b0;
      hyper_reset_ni = 1'b1;
      hyper_cs_ni = 1'b1;
      hyper_dq_i = 8'h00;
      hyper_rwds_i = 1'b0;
      repeat (3) @(posedge clk_i);
      #1;
      check("rst_dq", 32'(hyper_dq_o), 32'd0);
      check("rst_dq_oe", 32'(hyper_dq_oe_o), 32'd0);
      check("rst_rwds", 32'(hyper_rwds_o), 32'd0);
      check("rst_rwds_oe", 32'(hyper_rwds_oe_o), 32'd0);
      check("rst_cr0", 32'(cr0_o), 32'h8F1F);
      rst_ni = 1'b1;
      @(posedge clk_i);
      #1;

      for (int k = 0; k < 13; k++) run_txn(vec[k], k);

      // Aborted read: first byte in cycle 30, CS high in cycles 31-32, new CA at cycle 33
      send_ca(1'b1, 1'b0, 1'b1, 32'h10);
      repeat (Lat) step(1'b0, 8'h00, 1'b0);
      step(1'b0, 8'h00, 1'b0);
      check("abort_byte0", 32'(s_dq), 32'h09);
      step(1'b1, 8'h00, 1'b0);
      check("abort_dq_oe", 32'(s_dq_oe), 32'd0);
      check("abort_rwds_oe", 32'(s_rwds_oe), 32'd0);
      step(1'b1, 8'h00, 1'b0);
      $display("txn abort: read at w=10 aborted in cycle 31");
      run_txn(rb_1f_2, 13);

      // Device reset during latency
      send_ca(1'b1, 1'b0, 1'b1, 32'h1F);
      repeat (10) step(1'b0, 8'h00, 1'b0);
      hyper_reset_ni = 1'b0;
      step(1'b0, 8'h00, 1'b0);
      hyper_reset_ni = 1'b1;
      step(1'b0, 8'h00, 1'b0);
      check("hrst_dq_oe", 32'(s_dq_oe), 32'd0);
      check("hrst_rwds_oe", 32'(s_rwds_oe), 32'd0);
      check("hrst_cr0", 32'(cr0_o), 32'h8F1F);
      step(1'b1, 8'h00, 1'b0);
      $display("txn hreset: device reset during latency");
      run_txn(rb_1f_4, 14);

      // Asynchronous reset in the middle of a read
      send_ca(1'b1, 1'b0, 1'b1, 32'h1F);
      repeat (Lat) step(1'b0, 8'h00, 1'b0);
      step(1'b0, 8'h00, 1'b0);
      check("arst_pre_data", 32'(s_dq), 32'h07);
      check("arst_pre_dq_oe", 32'(s_dq_oe), 32'd1);
      hyper_cs_ni = 1'b0;
      #2;
      rst_ni = 1'b0;
      #1;
      check("arst_dq_oe", 32'(hyper_dq_oe_o), 32'd0);
      check("arst_rwds_oe", 32'(hyper_rwds_oe_o), 32'd0);
      check("arst_dq", 32'(hyper_dq_o), 32'd0);
      check("arst_rwds", 32'(hyper_rwds_o), 32'd0);
      @(posedge clk_i);
      #1;
      rst_ni = 1'b1;
      step(1'b1, 8'h00, 1'b0);
      $display("txn areset: async reset during read");

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end
endmodule
